// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the right-shift sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } seq_state_t;

  localparam logic MODE_ARITH = 1'b0;
  localparam logic MODE_LOGIC = 1'b1;

endpackage

// File: rtl/shift_seq_ctrl.sv
// Sequencer control: accepts a request, counts down the clamped shift amount
// one step per clock, then holds the response until the consumer takes it.
// Handshake outputs are registered so they depend on state only.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amt,
  input  logic             rsp_ready,
  output logic             load,
  output logic             step,
  output logic             req_ready,
  output logic             rsp_valid,
  output logic             busy
);

  seq_state_t       state;
  logic [AMT_W-1:0] cnt;
  logic [AMT_W-1:0] amt_clamped;

  // Amounts beyond the word width behave exactly like a full-width shift.
  always_comb begin
    amt_clamped = req_amt;
    if (req_amt > AMT_W'(WIDTH)) begin
      amt_clamped = AMT_W'(WIDTH);
    end
  end

  // Strobes for the datapath: capture on accept, shift once per SHIFT cycle.
  always_comb begin
    load = req_ready & req_valid;
    step = (state == SHIFT);
  end

  // Main FSM with down-counter and registered handshake/busy outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cnt       <= amt_clamped;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (amt_clamped == '0) begin
              state     <= DONE;
              rsp_valid <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          cnt <= cnt - 1'b1;
          if (cnt == AMT_W'(1)) begin
            state     <= DONE;
            rsp_valid <= 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/right_shift_sequencer.sv
// Variable-amount right shifter built from a single one-bit shift step that
// is applied once per clock under control of shift_seq_ctrl.
module right_shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic [AMT_W-1:0] req_amt,
  input  logic             req_mode,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  logic             load;
  logic             step;
  logic             mode_q;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_step;
  logic             fill_bit;

  shift_seq_ctrl #(
    .WIDTH(WIDTH),
    .AMT_W(AMT_W)
  ) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_amt  (req_amt),
    .rsp_ready(rsp_ready),
    .load     (load),
    .step     (step),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .busy     (busy)
  );

  // One-bit step: arithmetic replicates the sign bit, logical shifts in zero.
  always_comb begin
    fill_bit  = (mode_q == MODE_ARITH) ? work[WIDTH-1] : 1'b0;
    work_step = {fill_bit, work[WIDTH-1:1]};
  end

  // Work register: capture the word and mode on accept, shift while stepping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work   <= '0;
      mode_q <= MODE_ARITH;
    end else if (load) begin
      work   <= req_data;
      mode_q <= req_mode;
    end else if (step) begin
      work <= work_step;
    end
  end

  assign rsp_data = work;

endmodule

// File: tb/tb_right_shift_sequencer.sv
// Scoreboard bench for right_shift_sequencer: each accepted request pushes its
// expected result and response cycle; the monitor checks them on output.
module tb_right_shift_sequencer;
  import shift_seq_pkg::*;

  localparam int WIDTH = 16;
  localparam int AMT_W = 5;

  typedef struct {
    logic [WIDTH-1:0] data;
    int unsigned      due;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_data;
  logic [AMT_W-1:0] req_amt;
  logic             req_mode;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             busy;

  int unsigned cycle;
  int unsigned hsCycle;
  int          checks;
  int          errors;
  bit          inResponse;
  exp_t        expQ[$];

  right_shift_sequencer #(
    .WIDTH(WIDTH),
    .AMT_W(AMT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_data (req_data),
    .req_amt  (req_amt),
    .req_mode (req_mode),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .busy     (busy)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running cycle counter
  always @(posedge clk) cycle <= cycle + 1;

  // Count one comparison and report it on mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  // Reference result computed directly from the shift definition
  function automatic logic [WIDTH-1:0] modelShift(input logic [WIDTH-1:0] d,
                                                  input int amt, input logic mode);
    int n;
    logic signed [WIDTH-1:0] s;
    n = (amt > WIDTH) ? WIDTH : amt;
    s = d;
    if (mode == MODE_LOGIC) return d >> n;
    return s >>> n;
  endfunction

  // Drive a request, wait (bounded) for acceptance, push expected result
  task automatic applyStimulus(input logic [WIDTH-1:0] d, input int amt,
                               input logic mode, output int unsigned acceptCycle);
    int n;
    bit accepted;
    exp_t e;
    n = (amt > WIDTH) ? WIDTH : amt;
    req_data  = d;
    req_amt   = AMT_W'(amt);
    req_mode  = mode;
    req_valid = 1'b1;
    accepted  = 1'b0;
    acceptCycle = 0;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      if (req_ready) begin
        accepted    = 1'b1;
        acceptCycle = cycle;
        e.data = modelShift(d, amt, mode);
        e.due  = cycle + 1 + n;
        expQ.push_back(e);
      end
    end
    if (!accepted) checkOutput("accept_timeout", {31'b0, accepted}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Wait (bounded) for all outstanding results to be consumed
  task automatic waitDrain();
    for (int i = 0; i < 100 && expQ.size() != 0; i++) @(negedge clk);
    checkOutput("drain", expQ.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Response monitor: latency on first valid cycle, data every valid cycle
  always @(negedge clk) begin
    if (reset) begin
      inResponse = 1'b0;
    end else if (rsp_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_rsp", {31'b0, rsp_valid}, 32'd0);
      end else begin
        if (!inResponse) checkOutput("latency", cycle, expQ[0].due);
        inResponse = 1'b1;
        checkOutput("rsp_data", {16'b0, rsp_data}, {16'b0, expQ[0].data});
        if (rsp_ready) begin
          hsCycle = cycle;
          void'(expQ.pop_front());
          inResponse = 1'b0;
        end
      end
    end
  end

  // Global time limit
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int unsigned acc;
    int unsigned acc2;
    int validCount;
    cycle     = 0;
    hsCycle   = 0;
    checks    = 0;
    errors    = 0;
    inResponse = 1'b0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_data  = '0;
    req_amt   = '0;
    req_mode  = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rst_rsp_data", {16'b0, rsp_data}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Basic arithmetic / logical / positive word
    applyStimulus(16'hF000, 4, MODE_ARITH, acc);
    waitDrain();
    applyStimulus(16'hF000, 4, MODE_LOGIC, acc);
    waitDrain();
    applyStimulus(16'h7FF0, 4, MODE_ARITH, acc);
    waitDrain();

    // Zero amount: busy for exactly one cycle
    applyStimulus(16'h8001, 0, MODE_ARITH, acc);
    @(negedge clk);
    checkOutput("zero_busy_on", {31'b0, busy}, 32'd1);
    @(negedge clk);
    checkOutput("zero_busy_off", {31'b0, busy}, 32'd0);
    waitDrain();

    // Clamp cases
    applyStimulus(16'h8000, 16, MODE_ARITH, acc);
    waitDrain();
    applyStimulus(16'h8000, 20, MODE_ARITH, acc);
    waitDrain();
    applyStimulus(16'h8000, 16, MODE_LOGIC, acc);
    waitDrain();
    applyStimulus(16'h8000, 31, MODE_LOGIC, acc);
    waitDrain();

    // A few random requests
    for (int i = 0; i < 6; i++) begin
      applyStimulus(16'($urandom), int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)), acc);
      waitDrain();
    end

    // Backpressure with a second request waiting
    rsp_ready = 1'b0;
    applyStimulus(16'hA5A5, 3, MODE_LOGIC, acc);
    fork
      applyStimulus(16'h9234, 2, MODE_ARITH, acc2);
      begin
        for (int i = 0; i < 50 && !rsp_valid; i++) @(negedge clk);
        checkOutput("bp_valid_seen", {31'b0, rsp_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk);
          checkOutput("bp_req_ready", {31'b0, req_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
      end
    join
    checkOutput("bp_accept_cycle", acc2, hsCycle + 1);
    waitDrain();

    // Reset two cycles into an 8-step shift
    applyStimulus(16'h1234, 8, MODE_ARITH, acc);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("abort_req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("abort_rsp_data", {16'b0, rsp_data}, 32'd0);
    checkOutput("abort_busy", {31'b0, busy}, 32'd0);
    expQ.delete();
    @(negedge clk);
    reset = 1'b0;
    validCount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid) validCount++;
    end
    checkOutput("abort_no_rsp", validCount, 0);
    @(posedge clk);
    #1;
    applyStimulus(16'h8421, 3, MODE_LOGIC, acc);
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
